// File: rtl/dpram_read_streamer_if.sv
// Control, RAM read port and output stream of the dual-port RAM read streamer.
// "slave" is the streamer side; "master" is the surrounding RAM/consumer/controller.
interface dpram_read_streamer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport slave (
    input  start, base_addr, len, ram_dout, m_ready,
    output busy, done, ram_en, ram_we, ram_addr, m_valid, m_data
  );

  modport master (
    output start, base_addr, len, ram_dout, m_ready,
    input  busy, done, ram_en, ram_we, ram_addr, m_valid, m_data
  );
endinterface

// File: rtl/dpram_read_streamer.sv
// Sweeps one RAM port with reads and replays the words on a valid/ready stream,
// hiding the RAM read latency behind a small FIFO sized to what can be in flight.
module dpram_read_streamer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpram_read_streamer_if.slave bus
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = (DEPTH > 2) ? 2 : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remain_reg;
  logic [RD_LAT-1:0] infl_reg;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     fifo_cnt_reg;

  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] infl_cnt;
  logic [OW-1:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl_cnt = infl_cnt + OW'(infl_reg[i]);
    end
  end

  assign pop   = (fifo_cnt_reg != '0) && bus.m_ready;
  assign push  = infl_reg[RD_LAT-1];
  // Slots already claimed after this cycle's pop; a read is issued only if it still has a home.
  assign occ   = OW'(fifo_cnt_reg) + infl_cnt - OW'(pop);
  assign issue = (state_reg == S_RUN) && (occ < OW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      infl_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        infl_reg[i] <= infl_reg[i-1];
      end
      if (push) begin
        fifo_mem[wr_ptr_reg] <= bus.ram_dout;
        wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      fifo_cnt_reg <= fifo_cnt_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      addr_reg   <= '0;
      remain_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            busy_reg <= 1'b1;
            if (bus.len == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg  <= S_RUN;
              addr_reg   <= bus.base_addr;
              remain_reg <= bus.len;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            remain_reg <= remain_reg - 1'b1;
            // The address is left on the final read so the port rests on the last word fetched.
            if (remain_reg == (ADDR_W+1)'(1)) begin
              state_reg <= S_DRAIN;
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (pop && (fifo_cnt_reg == CW'(1)) && (infl_cnt == '0)) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.ram_en   = issue;
  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = addr_reg;
  assign bus.m_valid  = (fifo_cnt_reg != '0);
  assign bus.m_data   = fifo_mem[rd_ptr_reg];
endmodule

// File: tb/tb_dpram_read_streamer.sv
// Directed bench: behavioural dual-port RAM plus a cycle-by-cycle monitor of the stream.
module tb_dpram_read_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_read_streamer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  dpram_read_streamer #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM: port B is the bench's write port, port A is the streamer's read port.
  logic [15:0] mem [256];
  logic        b_we = 1'b0;
  logic [7:0]  b_addr = '0;
  logic [15:0] b_din = '0;
  always @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_din;
    if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] got[$];
  logic [7:0]  addrs[$];
  logic [15:0] exp_d[$];
  logic [7:0]  exp_a[$];
  int first_v, done_c, busy_bad, we_bad, stall_bad, occ_bad, stalls;
  logic [15:0] ready_pat = 16'b0110_1001_1100_1001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ram_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    b_we = 1'b1; b_addr = a; b_din = d;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic check_data(input string tag);
    check({tag, "_count"}, got.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got[i], exp_d[i]);
  endtask

  task automatic check_addrs(input string tag);
    check({tag, "_acount"}, addrs.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < addrs.size(); i++)
      check($sformatf("%s_a%0d", tag, i), addrs[i], exp_a[i]);
  endtask

  // Runs one transfer; cycle c is the clock period following the c-th edge after start is sampled.
  task automatic do_xfer(input string tag, input logic [7:0] base, input logic [8:0] n,
                         input bit bp, input bit ign);
    logic [15:0] stall_data;
    bit stalled;
    int issued, accepted;
    got.delete(); addrs.delete();
    first_v = -1; done_c = -1; busy_bad = 0; we_bad = 0; stall_bad = 0; occ_bad = 0;
    stalls = 0; issued = 0; accepted = 0; stalled = 0; stall_data = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.len = n; bus.m_ready = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      bus.start = ign && (c == 3);
      if (ign) begin
        bus.base_addr = 8'h40; bus.len = 9'd5;
      end
      bus.m_ready = bp ? ready_pat[c % 16] : 1'b1;
      #1;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.ram_we !== 1'b0) we_bad++;
      if (stalled && (bus.m_valid !== 1'b1 || bus.m_data !== stall_data)) stall_bad++;
      if (bus.ram_en === 1'b1) begin
        addrs.push_back(bus.ram_addr); issued++;
      end
      if (bus.m_valid === 1'b1 && first_v < 0) first_v = c;
      if (bus.m_valid === 1'b1 && bus.m_ready) begin
        got.push_back(bus.m_data); accepted++;
      end
      stalled = (bus.m_valid === 1'b1) && !bus.m_ready;
      if (stalled) begin
        stalls++; stall_data = bus.m_data;
      end
      if (issued - accepted > 2) occ_bad++;
      if (bus.done === 1'b1) begin
        done_c = c;
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, done_c > 0, 1);
    check({tag, "_busy_during"}, busy_bad, 0);
    check({tag, "_we_zero"}, we_bad, 0);
    @(negedge clk);
    #1;
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_done_after"}, bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    rst_n = 1'b1;

    ram_write(8'h00, 16'd9);  ram_write(8'h01, 16'd10); ram_write(8'h02, 16'd7);
    ram_write(8'h03, 16'd7);  ram_write(8'h04, 16'd6);  ram_write(8'h05, 16'd8);

    exp_d = {16'd9, 16'd10, 16'd7, 16'd7, 16'd6, 16'd8};
    exp_a = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_xfer("burst", 8'h00, 9'd6, 1'b0, 1'b0);
    check_data("burst");
    check_addrs("burst");
    check("burst_first_valid", first_v, 3);
    check("burst_done_cycle", done_c, 9);
    check("burst_addr_hold", bus.ram_addr, 8'h05);

    exp_d.delete(); exp_a.delete();
    do_xfer("len0", 8'h10, 9'd0, 1'b0, 1'b0);
    check("len0_done_cycle", done_c, 1);
    check("len0_no_ram_en", addrs.size(), 0);
    check("len0_no_valid", first_v, -1);
    check("len0_addr_hold", bus.ram_addr, 8'h05);

    exp_d = {16'd9, 16'd10, 16'd7, 16'd7, 16'd6, 16'd8};
    exp_a = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_xfer("bp", 8'h00, 9'd6, 1'b1, 1'b0);
    check_data("bp");
    check_addrs("bp");
    check("bp_stable", stall_bad, 0);
    check("bp_capacity", occ_bad, 0);
    check("bp_stalled", stalls > 0, 1);

    do_xfer("ign", 8'h00, 9'd6, 1'b0, 1'b1);
    check_data("ign");
    check_addrs("ign");
    check("ign_done_cycle", done_c, 9);

    // Reset with two words accepted and further reads still in flight.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 8'h00; bus.len = 9'd6; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("mid_valid_pre", bus.m_valid, 1);
    check("mid_data_pre", bus.m_data, 16'd7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_ram_en", bus.ram_en, 0);
    check("mid_rst_ram_addr", bus.ram_addr, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_d = {16'd7, 16'd7};
    exp_a = {8'h02, 8'h03};
    do_xfer("post_rst", 8'h02, 9'd2, 1'b0, 1'b0);
    check_data("post_rst");
    check_addrs("post_rst");
    check("post_rst_done_cycle", done_c, 5);

    ram_write(8'hFE, 16'hAAAA); ram_write(8'hFF, 16'hBBBB);
    ram_write(8'h00, 16'h1111); ram_write(8'h01, 16'h2222);
    exp_d = {16'hAAAA, 16'hBBBB, 16'h1111, 16'h2222};
    exp_a = {8'hFE, 8'hFF, 8'h00, 8'h01};
    do_xfer("wrap", 8'hFE, 9'd4, 1'b0, 1'b0);
    check_data("wrap");
    check_addrs("wrap");
    check("wrap_done_cycle", done_c, 7);

    exp_d.delete(); exp_a.delete();
    for (int i = 0; i < 256; i++) begin
      ram_write(8'(i), 16'h1000 + 16'(i * 3));
      exp_d.push_back(16'h1000 + 16'(i * 3));
      exp_a.push_back(8'(i));
    end
    do_xfer("full", 8'h00, 9'd256, 1'b0, 1'b0);
    check_data("full");
    check_addrs("full");
    check("full_done_cycle", done_c, 259);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/dpram_read_streamer.md
# dpram_read_streamer

Read-side companion to the true dual-port RAM. Given a base address and word count, it sweeps one RAM port with read-only accesses (enable high, write-enable low). It absorbs the RAM's synchronous read latency and delivers the words, in address order, on a valid/ready output stream that tolerates backpressure. It sits between the RAM port and any consumer that needs contents written through the other port, such as a checker, DMA or UART dump.

## Interface
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM data width.
- `RD_LAT`, 1: RAM read latency in clocks, from the edge that samples `ram_en` to `ram_dout` being valid. Legal values are 1 and 2.

- `clk` input 1: single clock; RAM port and stream share it.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `base_addr` input ADDR_W: first address; captured with `start`.
- `len` input ADDR_W+1: number of words, 0..2^ADDR_W; captured with `start`.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle completion pulse.
- `ram_en` output 1: RAM port enable.
- `ram_we` output 1: RAM write enable; constant 0.
- `ram_addr` output ADDR_W: RAM address.
- `ram_dout` input DATA_W: RAM read data.
- `m_valid` output 1: stream data valid.
- `m_ready` input 1: consumer accepts.
- `m_data` output DATA_W: stream data.

## Operation
- States:
  - IDLE: the only state in which `start` is honoured.
  - RUN: issuing reads.
  - DRAIN: all reads issued; waiting for the buffer to empty.
  - DONE: single cycle; `done`=1, then return to IDLE.
- Transitions:
  - IDLE to RUN on `start` with `len`≠0.
  - IDLE to DONE on `start` with `len`=0. No RAM access; `m_valid` never rises.
  - RUN to DRAIN when the last read is issued.
  - DRAIN to DONE on the cycle the last word is accepted (`m_valid`&&`m_ready`).
  - A `start` arriving outside IDLE is ignored.
- Address generation:
  - The first read is at `base_addr`; each later read is at the previous address +1, modulo 2^ADDR_W.
  - Wrap-around is silent: base 0xFE with len 4 reads FE, FF, 00, 01.
- Output buffer:
  - FIFO of depth RD_LAT+1.
  - An in-flight shift register of RD_LAT valid bits tracks outstanding reads.
  - A word enters the FIFO when its in-flight bit emerges.
- Issue rule: assert `ram_en` in RUN only when (FIFO count + in-flight count − pop-this-cycle) < RD_LAT+1. The FIFO therefore never overflows, and no read is issued that cannot be stored.
- `m_data` is the FIFO head. While `m_valid`=1 and `m_ready`=0, `m_valid` and `m_data` stay stable.
- A remaining-words counter of ADDR_W+1 bits is loaded from `len` and decremented per issued read.
- Reset, including mid-transfer: return to IDLE and clear the FIFO, in-flight bits and counters. RAM data still in flight is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `m_valid`=0, `m_data`=0.
- Let `start` be sampled at edge E0.
  - `busy`=1 from the cycle after E0 through the DONE cycle inclusive.
  - The first `ram_en`=1 occurs in the cycle after E0, with `ram_addr`=`base_addr`.
- Read latency: a read issued in cycle k returns its word on `m_valid` in cycle k+RD_LAT+1. With RD_LAT=1, `m_valid` first rises 3 cycles after E0.
- Throughput: with `m_ready` held at 1, one word per clock. N words complete with `done` at cycle N+RD_LAT+2 after E0.
- Backpressure: when `m_ready` drops, `ram_en` stops within the same cycle once the buffer plus in-flight reads would exceed capacity. No word is lost or duplicated.
- `ram_en` is 0 whenever the state is not RUN.
- `ram_addr` holds its last value when idle.
- For `len`=0: `done` occurs 1 cycle after E0 and `busy` is 1 for that cycle only.

## Test plan
- Burst readback:
  - Stimulus: preload addresses 0–5 with 9, 10, 7, 7, 6, 8 via the other RAM port. Start base=0, len=6, `m_ready`=1.
  - Required: stream 9, 10, 7, 7, 6, 8 on consecutive cycles; first `m_valid` 3 cycles after `start`; `done` at cycle 9; `ram_we` always 0.
- Backpressure:
  - Stimulus: same preload and start, with `m_ready` toggling 1,0,0,1,… pseudo-randomly.
  - Required: identical data sequence; `m_data` stable while stalled; FIFO never exceeds 2 entries.
- Wrap:
  - Stimulus: preload FE=0xAAAA, FF=0xBBBB, 00=0x1111, 01=0x2222. Start base=0xFE, len=4.
  - Required: output in that order; `ram_addr` sequence FE, FF, 00, 01.
- Zero and full length:
  - len=0 → `done` 1 cycle after `start`, no `ram_en`, no `m_valid`.
  - len=256 → exactly 256 words, addresses 00..FF.
- Ignored start: pulse `start` with base=0x40 during a transfer → the current transfer completes unchanged and nothing is read at 0x40.
- Reset mid-transfer:
  - Stimulus: drop `rst_n` after 2 words accepted with reads in flight.
  - Required: all outputs return to reset values immediately. After release, a new transfer of base=2, len=2 yields 7, 7 with no stale words.
